// File: rtl/control_merge_rr_if.sv
// Handshake bundle for control_merge_rr.
//   ins / ins_valid / ins_ready        : SIZE packed input channels, channel i
//                                         at ins[i*DATA_WIDTH +: DATA_WIDTH]
//   outs / outs_valid / outs_ready     : merged data channel
//   index / index_valid / index_ready  : winning-channel number channel
// The slave modport is the merge's view; master is the environment's view.
interface control_merge_rr_if #(
   parameter int SIZE        = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 1
);
   logic [SIZE*DATA_WIDTH-1:0] ins;
   logic [SIZE-1:0]            ins_valid;
   logic [SIZE-1:0]            ins_ready;
   logic [DATA_WIDTH-1:0]      outs;
   logic                       outs_valid;
   logic                       outs_ready;
   logic [INDEX_WIDTH-1:0]     index;
   logic                       index_valid;
   logic                       index_ready;

   modport slave (
      input  ins, ins_valid, outs_ready, index_ready,
      output ins_ready, outs, outs_valid, index, index_valid
   );

   modport master (
      output ins, ins_valid, outs_ready, index_ready,
      input  ins_ready, outs, outs_valid, index, index_valid
   );
endinterface

// File: rtl/control_merge_rr.sv
// Round-robin control merge with a registered output slot.
// Picks one valid input token per cycle (round-robin starting at ptr), stores
// its data and channel number in a one-entry slot, and offers them on two
// independent output channels (data and index) that fork eagerly: each output
// fires once per token and the slot frees once both have been taken.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (rst==0 clears slot, flags, pointer)
//   bus  : control_merge_rr_if.slave (ins*, outs*, index* handshakes)
module control_merge_rr #(
   parameter int SIZE        = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 1
) (
   input  logic              clk,
   input  logic              rst,
   control_merge_rr_if.slave bus
);

   logic                   vld_p0;
   logic                   outs_sent_p0;
   logic                   index_sent_p0;
   logic [DATA_WIDTH-1:0]  data_p0;
   logic [INDEX_WIDTH-1:0] idx_p0;
   logic [INDEX_WIDTH-1:0] ptr;

   logic [INDEX_WIDTH-1:0] win;
   logic [DATA_WIDTH-1:0]  win_data;
   logic                   any_v;
   logic                   done_o;
   logic                   done_i;
   logic                   slot_free;
   logic                   accept;
   logic [INDEX_WIDTH-1:0] ptr_nxt;

   // Winner = valid channel at the smallest circular distance from ptr.
   always_comb begin
      int best_d;
      int d;
      win    = '0;
      any_v  = 1'b0;
      best_d = SIZE;
      for (int i = 0; i < SIZE; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + SIZE;
         if (bus.ins_valid[i] && d < best_d) begin
            best_d = d;
            win    = INDEX_WIDTH'(i);
            any_v  = 1'b1;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (win == INDEX_WIDTH'(i)) win_data = bus.ins[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.outs_valid  = vld_p0 & ~outs_sent_p0;
   assign bus.index_valid = vld_p0 & ~index_sent_p0;
   assign bus.outs        = data_p0;
   assign bus.index       = idx_p0;

   assign done_o    = outs_sent_p0  | (bus.outs_valid  & bus.outs_ready);
   assign done_i    = index_sent_p0 | (bus.index_valid & bus.index_ready);
   // The slot can drain and refill in the same cycle.
   assign slot_free = ~vld_p0 | (done_o & done_i);
   assign accept    = slot_free & any_v;
   assign ptr_nxt   = (int'(win) == SIZE - 1) ? '0 : INDEX_WIDTH'(int'(win) + 1);

   always_comb begin
      bus.ins_ready = '0;
      for (int i = 0; i < SIZE; i++) begin
         bus.ins_ready[i] = rst & accept & (win == INDEX_WIDTH'(i));
      end
   end

   // Stage p0: output slot and fork flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p0        <= 1'b0;
         outs_sent_p0  <= 1'b0;
         index_sent_p0 <= 1'b0;
         ptr           <= '0;
         data_p0       <= '0;
         idx_p0        <= '0;
      end else if (accept) begin
         vld_p0        <= 1'b1;
         data_p0       <= win_data;
         idx_p0        <= win;
         ptr           <= ptr_nxt;
         outs_sent_p0  <= 1'b0;
         index_sent_p0 <= 1'b0;
      end else if (vld_p0 & done_o & done_i) begin
         vld_p0        <= 1'b0;
         outs_sent_p0  <= 1'b0;
         index_sent_p0 <= 1'b0;
      end else begin
         // Remember which side already took the token so it never re-fires.
         outs_sent_p0  <= done_o & vld_p0;
         index_sent_p0 <= done_i & vld_p0;
      end
   end

endmodule

// File: tb/tb_control_merge_rr.sv
module tb_control_merge_rr;
   localparam int SIZE = 2;
   localparam int DW   = 32;
   localparam int IW   = 1;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   control_merge_rr_if #(.SIZE(SIZE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

   control_merge_rr #(.SIZE(SIZE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ins(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] v);
      bus.ins       = {d1, d0};
      bus.ins_valid = v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // T1: reset held with all inputs valid
   task automatic test_reset();
      rst = 1'b0;
      set_ins(32'h11, 32'h22, 2'b11);
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (bus.ins_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ins_ready c%0d: got %b expected 00", c, bus.ins_ready);
         end
         n_cmp++;
         if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_outputs c%0d: got ov=%b iv=%b idx=%0h outs=%0h expected all 0",
                     c, bus.outs_valid, bus.index_valid, bus.index, bus.outs);
         end
         tick();
      end
   endtask

   // T2: one token through channel 0
   task automatic test_single();
      rst = 1'b1;
      set_ins(32'hA5, 32'h0, 2'b01);
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.ins_ready !== 2'b01) begin
         n_err++;
         $display("FAIL single_accept: got %b expected 01", bus.ins_ready);
      end
      tick();
      set_ins(32'h0, 32'h0, 2'b00);
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs} !== {1'b1, 1'b1, 1'b0, 32'hA5}) begin
         n_err++;
         $display("FAIL single_out: got ov=%b iv=%b idx=%0h outs=%0h expected 1 1 0 a5",
                  bus.outs_valid, bus.index_valid, bus.index, bus.outs);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL single_once: got ov=%b iv=%b expected 0 0", bus.outs_valid, bus.index_valid);
      end
   endtask

   // T3: both channels valid, alternate one token per cycle
   task automatic test_fairness();
      do_reset();
      set_ins(32'h11, 32'h22, 2'b11);
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_cmp++;
         if (bus.ins_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL fair_ready k%0d: got %b expected %b", k, bus.ins_ready,
                     (k % 2 == 0) ? 2'b01 : 2'b10);
         end
         if (k > 0) begin
            n_cmp++;
            if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs} !==
                {1'b1, 1'b1, IW'((k - 1) % 2), ((k - 1) % 2 == 0) ? 32'h11 : 32'h22}) begin
               n_err++;
               $display("FAIL fair_out k%0d: got ov=%b iv=%b idx=%0h outs=%0h", k,
                        bus.outs_valid, bus.index_valid, bus.index, bus.outs);
            end
         end
         tick();
      end
   endtask

   // T4: data taken, index held back, then released
   task automatic test_eager_fork();
      do_reset();
      set_ins(32'h33, 32'h0, 2'b01);
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b0;
      tick();
      set_ins(32'h0, 32'h44, 2'b10);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if ({bus.outs_valid, bus.index_valid, bus.ins_ready} !== {(c == 0), 1'b1, 2'b00}) begin
            n_err++;
            $display("FAIL fork_hold c%0d: got ov=%b iv=%b rdy=%b expected ov=%b iv=1 rdy=00",
                     c, bus.outs_valid, bus.index_valid, bus.ins_ready, (c == 0));
         end
         tick();
      end
      bus.index_ready = 1'b1;
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid, bus.index, bus.ins_ready} !== {1'b0, 1'b1, 1'b0, 2'b10}) begin
         n_err++;
         $display("FAIL fork_release: got ov=%b iv=%b idx=%0h rdy=%b expected 0 1 0 10",
                  bus.outs_valid, bus.index_valid, bus.index, bus.ins_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs} !== {1'b1, 1'b1, 1'b1, 32'h44}) begin
         n_err++;
         $display("FAIL fork_refill: got ov=%b iv=%b idx=%0h outs=%0h expected 1 1 1 44",
                  bus.outs_valid, bus.index_valid, bus.index, bus.outs);
      end
   endtask

   // T5: both consumers stalled; slot holds 0x44/idx1, ptr is 0
   task automatic test_backpressure();
      bus.outs_ready  = 1'b0;
      bus.index_ready = 1'b0;
      set_ins(32'h55, 32'h66, 2'b11);
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs, bus.ins_ready} !==
             {1'b1, 1'b1, 1'b1, 32'h44, 2'b00}) begin
            n_err++;
            $display("FAIL bp_hold c%0d: got ov=%b iv=%b idx=%0h outs=%0h rdy=%b", c,
                     bus.outs_valid, bus.index_valid, bus.index, bus.outs, bus.ins_ready);
         end
         tick();
      end
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.ins_ready !== 2'b01) begin
         n_err++;
         $display("FAIL bp_ptr: got %b expected 01", bus.ins_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.index, bus.outs} !== {1'b0, 32'h55}) begin
         n_err++;
         $display("FAIL bp_next: got idx=%0h outs=%0h expected 0 55", bus.index, bus.outs);
      end
   endtask

   // T6: reset while the index side still owes a transfer
   task automatic test_midop_reset();
      set_ins(32'h0, 32'h0, 2'b00);
      bus.outs_ready  = 1'b1;
      bus.index_ready = 1'b0;
      tick();
      rst = 1'b0;
      set_ins(32'h77, 32'h88, 2'b11);
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid, bus.ins_ready} !== {1'b0, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL mid_pre: got ov=%b iv=%b rdy=%b expected 0 1 00",
                  bus.outs_valid, bus.index_valid, bus.ins_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.outs_valid, bus.index_valid, bus.outs} !== {1'b0, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL mid_cleared: got ov=%b iv=%b outs=%0h expected 0 0 0",
                  bus.outs_valid, bus.index_valid, bus.outs);
      end
      rst             = 1'b1;
      bus.index_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.ins_ready !== 2'b01) begin
         n_err++;
         $display("FAIL mid_ptr0: got %b expected 01", bus.ins_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.index, bus.outs} !== {1'b0, 32'h77}) begin
         n_err++;
         $display("FAIL mid_first: got idx=%0h outs=%0h expected 0 77", bus.index, bus.outs);
      end
   endtask

   // Random traffic against a cycle-level reference of the slot behaviour
   task automatic test_random();
      bit          m_full, m_os, m_is;
      int          m_ptr, m_idx;
      logic [DW-1:0] m_data;
      bit          any, ov, iv, d_o, d_i, free;
      int          w;
      logic [DW-1:0] wd;
      logic [SIZE-1:0] v, exp_rdy;
      logic [DW-1:0] chan [SIZE];

      do_reset();
      m_full = 0; m_os = 0; m_is = 0; m_ptr = 0; m_idx = 0; m_data = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < SIZE; i++) chan[i] = $urandom;
         v               = SIZE'($urandom_range(0, (1 << SIZE) - 1));
         bus.ins         = {chan[1], chan[0]};
         bus.ins_valid   = v;
         bus.outs_ready  = ($urandom_range(0, 3) != 0);
         bus.index_ready = ($urandom_range(0, 3) != 0);
         rst             = ($urandom_range(0, 63) != 0);

         ov  = m_full && !m_os;
         iv  = m_full && !m_is;
         any = 0;
         w   = 0;
         for (int k = 0; k < SIZE; k++) begin
            int c;
            c = (m_ptr + k) % SIZE;
            if (!any && v[c]) begin
               any = 1;
               w   = c;
            end
         end
         wd      = chan[w];
         d_o     = m_os || (ov && bus.outs_ready);
         d_i     = m_is || (iv && bus.index_ready);
         free    = !m_full || (d_o && d_i);
         exp_rdy = '0;
         if (rst && free && any) exp_rdy = SIZE'(1 << w);

         #1;
         n_cmp++;
         if ({bus.outs_valid, bus.index_valid, bus.index, bus.outs, bus.ins_ready} !==
             {ov, iv, IW'(m_idx), m_data, exp_rdy}) begin
            n_err++;
            $display("FAIL rand cyc%0d: got ov=%b iv=%b idx=%0h outs=%0h rdy=%b expected ov=%b iv=%b idx=%0h outs=%0h rdy=%b",
                     cyc, bus.outs_valid, bus.index_valid, bus.index, bus.outs, bus.ins_ready,
                     ov, iv, m_idx, m_data, exp_rdy);
         end

         if (!rst) begin
            m_full = 0; m_os = 0; m_is = 0; m_ptr = 0; m_data = '0; m_idx = 0;
         end else if (free && any) begin
            m_full = 1; m_data = wd; m_idx = w; m_ptr = (w + 1) % SIZE; m_os = 0; m_is = 0;
         end else if (m_full && d_o && d_i) begin
            m_full = 0; m_os = 0; m_is = 0;
         end else begin
            m_os = d_o && m_full;
            m_is = d_i && m_full;
         end
         tick();
      end
   endtask

   initial begin
      n_cmp           = 0;
      n_err           = 0;
      rst             = 1'b0;
      bus.ins         = '0;
      bus.ins_valid   = '0;
      bus.outs_ready  = 1'b0;
      bus.index_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_fairness();
      test_eager_fork();
      test_backpressure();
      test_midop_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
